cla_stream_controller: RTL and testbench

- Stream front/back end for the registered carry-lookahead adder.
- Accepts operand pairs on a valid/ready input, drives the adder's addend_0/addend_1 from registers, and tracks the adder's one-cycle registered latency.
- Captures adder sums into a small result FIFO presented on a valid/ready output.
- Credit-based admission means no result is ever dropped under downstream backpressure.

---
 rtl/cla_stream_controller_if.sv | 32 +++
 rtl/cla_stream_controller.sv | 99 +++++++++
 tb/tb_cla_stream_controller.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_stream_controller_if.sv
// Operand/result stream bundle for cla_stream_controller; out_sat exists only with CLA_STREAM_SAT_EN.
// master = the controller side, slave = the producer/consumer side.
interface cla_stream_controller_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
`ifdef CLA_STREAM_SAT_EN
    logic             out_sat;
`endif

    modport master (
        input  in_valid, in_a, in_b, out_ready,
`ifdef CLA_STREAM_SAT_EN
        output out_sat,
`endif
        output in_ready, out_valid, out_sum
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready,
`ifdef CLA_STREAM_SAT_EN
        input  out_sat,
`endif
        input  in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/cla_stream_controller.sv
// Stream wrapper around the registered CLA: operand regs -> adder -> result FIFO (CLA_STREAM_SAT_EN adds saturation).
// Latency: accept at E0, result visible on out_sum after E2 (adder registers at E1, FIFO captures at E2).
// Backpressure: in_ready is a credit check on registered state, so no result can ever be dropped.
module cla_stream_controller #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    cla_stream_controller_if.master strm,
    output logic [WIDTH-1:0]        addend_0,
    output logic [WIDTH-1:0]        addend_1,
    input  logic [WIDTH:0]          adder_sum,
    output logic                    busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            v1;
    logic            v2;
    logic            accept;
    logic            push;
    logic            pop;
    logic [CW:0]     inflight;
    logic [WIDTH:0]  wr_dat;

    // Every transaction past the input holds a credit until its result is popped.
    assign inflight      = {1'b0, count} + (CW+1)'(v1) + (CW+1)'(v2);
    assign strm.in_ready = ~reset & (inflight < (CW+1)'(FIFO_DEPTH));
    assign accept        = strm.in_valid & strm.in_ready;
    assign push          = v2;
    assign strm.out_valid = (count != '0);
    assign pop           = strm.out_valid & strm.out_ready;
    assign strm.out_sum  = mem[rd_ptr];
    assign busy          = v1 | v2 | (count != '0);

`ifdef CLA_STREAM_SAT_EN
    logic            sat_mem [FIFO_DEPTH];
    logic            wr_sat;

    assign wr_sat       = adder_sum[WIDTH];
    assign wr_dat       = wr_sat ? {1'b0, {WIDTH{1'b1}}} : adder_sum;
    assign strm.out_sat = sat_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) sat_mem[i] <= 1'b0;
        end else if (push) begin
            sat_mem[wr_ptr] <= wr_sat;
        end
    end
`else
    assign wr_dat = adder_sum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addend_0 <= '0;
            addend_1 <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
        end else begin
            if (accept) begin
                addend_0 <= strm.in_a;
                addend_1 <= strm.in_b;
            end
            v1 <= accept;
            v2 <= v1;
        end
    end

    // Storage is cleared on reset so no pre-reset result can reach out_sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count == CW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_cla_stream_controller.sv
// Bench for cla_stream_controller with a behavioural registered adder and a result scoreboard.
module tb_cla_stream_controller;
    localparam int W = 8;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  addend_0;
    logic [W-1:0]  addend_1;
    logic [W:0]    adder_sum;
    logic          busy;

    always #5 clk = ~clk;

    cla_stream_controller_if #(.WIDTH(W)) s ();

    cla_stream_controller #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .strm      (s),
        .addend_0  (addend_0),
        .addend_1  (addend_1),
        .adder_sum (adder_sum),
        .busy      (busy)
    );

    // Registered adder as seen by the controller; its reset_n is ~reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) adder_sum <= '0;
        else       adder_sum <= {1'b0, addend_0} + {1'b0, addend_1};
    end

    typedef struct {
        logic [W:0] sum;
        logic       sat;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   sum;
        logic         sat;
    } vec_t;

    int     checks   = 0;
    int     failures = 0;
    int     acc_cnt  = 0;
    int     pop_cnt  = 0;
    int     max_out  = 0;
    logic [W:0] last_sum = '0;
    res_t   sb[$];

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        r.sum = {1'b0, a} + {1'b0, b};
        r.sat = 1'b0;
`ifdef CLA_STREAM_SAT_EN
        if (r.sum[W]) begin
            r.sum = 9'h0FF;
            r.sat = 1'b1;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((busy || s.out_valid) && n < max_cyc) begin
            step();
            n++;
        end
        chk({name, "_idle_timeout"}, {31'b0, busy | s.out_valid}, 32'd0);
    endtask

    // Inputs change at posedge+1, so negedge sees exactly what the next edge will act on.
    always @(negedge clk) begin
        if (!reset) begin
            if (s.in_valid && s.in_ready) begin
                sb.push_back(model(s.in_a, s.in_b));
                acc_cnt++;
            end
            if (s.out_valid && s.out_ready) begin
                pop_cnt++;
                last_sum = s.out_sum;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_result", {23'b0, s.out_sum}, 32'hFFFF_FFFF);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    chk("sb_sum", {23'b0, s.out_sum}, {23'b0, e.sum});
`ifdef CLA_STREAM_SAT_EN
                    chk("sb_sat", {31'b0, s.out_sat}, {31'b0, e.sat});
`endif
                end
            end
            if (acc_cnt - pop_cnt > max_out) max_out = acc_cnt - pop_cnt;
        end
    end

    initial begin
        vec_t vecs[6];
        int   base;
        int   sent;
        int   cyc;
        logic acc;

        vecs[0] = '{a: 8'd200, b: 8'd100, sum: 9'h12C, sat: 1'b0};
`ifdef CLA_STREAM_SAT_EN
        vecs[1] = '{a: 8'd255, b: 8'd255, sum: 9'h0FF, sat: 1'b1};
        vecs[2] = '{a: 8'd255, b: 8'd1,   sum: 9'h0FF, sat: 1'b1};
`else
        vecs[1] = '{a: 8'd255, b: 8'd255, sum: 9'h1FE, sat: 1'b0};
        vecs[2] = '{a: 8'd255, b: 8'd1,   sum: 9'h100, sat: 1'b0};
`endif
        vecs[3] = '{a: 8'd3,   b: 8'd4,   sum: 9'h007, sat: 1'b0};
        vecs[4] = '{a: 8'd0,   b: 8'd0,   sum: 9'h000, sat: 1'b0};
        vecs[5] = '{a: 8'd128, b: 8'd127, sum: 9'h0FF, sat: 1'b0};

        reset       = 1'b1;
        s.in_valid  = 1'b0;
        s.in_a      = '0;
        s.in_b      = '0;
        s.out_ready = 1'b0;

        step();
        chk("rst_out_valid", {31'b0, s.out_valid}, 32'd0);
        chk("rst_out_sum",   {23'b0, s.out_sum},   32'd0);
        chk("rst_busy",      {31'b0, busy},        32'd0);
        chk("rst_in_ready",  {31'b0, s.in_ready},  32'd0);
        chk("rst_addend_0",  {24'b0, addend_0},    32'd0);
        chk("rst_addend_1",  {24'b0, addend_1},    32'd0);
`ifdef CLA_STREAM_SAT_EN
        chk("rst_out_sat",   {31'b0, s.out_sat},   32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, s.in_ready}, 32'd1);

        // Single transactions: exact E0/E1/E2 latency, value and drain.
        for (int i = 0; i < 6; i++) begin
            s.in_valid = 1'b1;
            s.in_a     = vecs[i].a;
            s.in_b     = vecs[i].b;
            step();
            s.in_valid = 1'b0;
            chk("vec_addend_0", {24'b0, addend_0}, {24'b0, vecs[i].a});
            chk("vec_addend_1", {24'b0, addend_1}, {24'b0, vecs[i].b});
            chk("vec_e0_out_valid", {31'b0, s.out_valid}, 32'd0);
            step();
            chk("vec_e1_out_valid", {31'b0, s.out_valid}, 32'd0);
            step();
            chk("vec_e2_out_valid", {31'b0, s.out_valid}, 32'd1);
            chk("vec_out_sum", {23'b0, s.out_sum}, {23'b0, vecs[i].sum});
`ifdef CLA_STREAM_SAT_EN
            chk("vec_out_sat", {31'b0, s.out_sat}, {31'b0, vecs[i].sat});
`endif
            s.out_ready = 1'b1;
            step();
            s.out_ready = 1'b0;
            chk("vec_pop_out_valid", {31'b0, s.out_valid}, 32'd0);
            chk("vec_pop_busy",      {31'b0, busy},        32'd0);
        end

        // Streaming: 16 back-to-back pairs, one result per cycle.
        base        = pop_cnt;
        s.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s.in_valid = 1'b1;
            s.in_a     = W'(i);
            s.in_b     = W'(i + 1);
            chk("stream_in_ready", {31'b0, s.in_ready}, 32'd1);
            step();
            if (i >= 2) chk("stream_out_valid", {31'b0, s.out_valid}, 32'd1);
        end
        s.in_valid = 1'b0;
        step();
        chk("stream_tail1_out_valid", {31'b0, s.out_valid}, 32'd1);
        step();
        chk("stream_tail2_out_valid", {31'b0, s.out_valid}, 32'd1);
        step();
        chk("stream_done_out_valid", {31'b0, s.out_valid}, 32'd0);
        chk("stream_pop_count", pop_cnt - base, 32'd16);

        // Backpressure: credits stop admission at exactly FIFO_DEPTH.
        s.out_ready = 1'b0;
        base        = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            s.in_valid = 1'b1;
            s.in_a     = W'(40 + i * 30);
            s.in_b     = W'(i * 7);
            step();
        end
        s.in_valid = 1'b0;
        chk("bp_accepted", acc_cnt - base, 32'd4);
        chk("bp_in_ready", {31'b0, s.in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, s.out_valid}, 32'd1);
        chk("bp_busy", {31'b0, busy}, 32'd1);
        base        = pop_cnt;
        s.out_ready = 1'b1;
        #1;
        chk("bp_no_comb_ready", {31'b0, s.in_ready}, 32'd0);
        step();
        chk("bp_ready_after_pop", {31'b0, s.in_ready}, 32'd1);
        wait_idle("bp", 20);
        chk("bp_drained", pop_cnt - base, 32'd4);

        // Reset with v1 = v2 = 1 and two results buffered.
        s.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s.in_valid = 1'b1;
            s.in_a     = W'(50 + i);
            s.in_b     = W'(i);
            step();
        end
        s.in_valid = 1'b0;
        chk("mid_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        sb.delete();
        acc_cnt = pop_cnt;
        #1;
        chk("mid_rst_out_valid", {31'b0, s.out_valid}, 32'd0);
        chk("mid_rst_busy",      {31'b0, busy},        32'd0);
        chk("mid_rst_addend_0",  {24'b0, addend_0},    32'd0);
        chk("mid_rst_addend_1",  {24'b0, addend_1},    32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("mid_rel_in_ready", {31'b0, s.in_ready}, 32'd1);
        base        = pop_cnt;
        s.out_ready = 1'b1;
        s.in_valid  = 1'b1;
        s.in_a      = 8'd7;
        s.in_b      = 8'd9;
        step();
        s.in_valid = 1'b0;
        repeat (10) step();
        chk("mid_one_result", pop_cnt - base, 32'd1);
        chk("mid_result_sum", {23'b0, last_sum}, 32'd16);

        // Pointer wrap with out_ready toggling every cycle.
        base    = pop_cnt;
        max_out = 0;
        sent    = 0;
        cyc     = 0;
        while (sent < 10 && cyc < 200) begin
            s.out_ready = cyc[0];
            s.in_valid  = 1'b1;
            s.in_a      = W'(200 + 17 * sent);
            s.in_b      = W'(60 + 5 * sent);
            acc         = s.in_ready;
            step();
            if (acc) sent++;
            cyc++;
        end
        s.in_valid = 1'b0;
        chk("wrap_all_sent", sent, 32'd10);
        while ((busy || s.out_valid) && cyc < 300) begin
            s.out_ready = cyc[0];
            step();
            cyc++;
        end
        s.out_ready = 1'b0;
        chk("wrap_idle", {31'b0, busy | s.out_valid}, 32'd0);
        chk("wrap_pop_count", pop_cnt - base, 32'd10);
        chk("wrap_max_outstanding_le_depth", {31'b0, max_out > D}, 32'd0);

        chk("sb_empty_at_end", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
